// File: rtl/shot_rect_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shot_rect_controller: shot lifecycle FSM plus per-pixel rectangle/offsets |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module shot_rect_controller #(
  parameter int OBJECT_WIDTH_X  = 16,
  parameter int OBJECT_HEIGHT_Y = 16,
  parameter int SCREEN_WIDTH    = 640,
  parameter int SPEED_Y         = 4,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        fire,
  input  logic [10:0] launchX,
  input  logic [10:0] launchY,
  input  logic        collision,
  output logic        InsideRectangle,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        shotActive,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam int              CNT_W    = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [10:0]     MAX_X    = 11'(SCREEN_WIDTH - OBJECT_WIDTH_X);
  localparam logic [10:0]     STEP_Y   = 11'(SPEED_Y);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic             shotActive_q;
  logic [10:0]      topLeftX_q;
  logic [10:0]      topLeftY_q;
  logic [CNT_W-1:0] cnt_q;

  logic             inside_q;
  logic [10:0]      offsetX_q;
  logic [10:0]      offsetY_q;

  logic             inside_d;
  logic [10:0]      offsetX_d;
  logic [10:0]      offsetY_d;
  logic [11:0]      xRight;
  logic [11:0]      yBottom;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      shotActive_q <= 1'b0;
      topLeftX_q   <= '0;
      topLeftY_q   <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fire) begin
            state_q      <= FLYING;
            shotActive_q <= 1'b1;
            topLeftX_q   <= (launchX > MAX_X) ? MAX_X : launchX;
            topLeftY_q   <= launchY;
          end
        end
        FLYING: begin
          // collision wins over the frame step; leaving the top does not wrap
          if (collision || (startOfFrame && (topLeftY_q < STEP_Y))) begin
            state_q      <= COOLDOWN;
            shotActive_q <= 1'b0;
            cnt_q        <= CNT_LOAD;
          end else if (startOfFrame) begin
            topLeftY_q <= topLeftY_q - STEP_Y;
          end
        end
        COOLDOWN: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else if (startOfFrame) begin
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          shotActive_q <= 1'b0;
        end
      endcase
    end
  end

  // bounds in 12 bits so a shot near the 11-bit limit cannot wrap
  always_comb begin
    xRight    = {1'b0, topLeftX_q} + 12'(OBJECT_WIDTH_X - 1);
    yBottom   = {1'b0, topLeftY_q} + 12'(OBJECT_HEIGHT_Y - 1);
    inside_d  = shotActive_q
                && (pixelX >= topLeftX_q) && ({1'b0, pixelX} <= xRight)
                && (pixelY >= topLeftY_q) && ({1'b0, pixelY} <= yBottom);
    offsetX_d = inside_d ? (pixelX - topLeftX_q) : 11'd0;
    offsetY_d = inside_d ? (pixelY - topLeftY_q) : 11'd0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inside_q  <= 1'b0;
      offsetX_q <= '0;
      offsetY_q <= '0;
    end else begin
      inside_q  <= inside_d;
      offsetX_q <= offsetX_d;
      offsetY_q <= offsetY_d;
    end
  end

  assign InsideRectangle = inside_q;
  assign offsetX         = offsetX_q;
  assign offsetY         = offsetY_q;
  assign shotActive      = shotActive_q;
  assign topLeftX        = topLeftX_q;
  assign topLeftY        = topLeftY_q;

endmodule
`default_nettype wire

// File: tb/tb_shot_rect_controller.sv
`default_nettype none
// Bench for shot_rect_controller: directed sequences, a rectangle vector table
// and a randomized run against a frame-level reference model.
module tb_shot_rect_controller;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY, launchX, launchY;
  logic        fire, collision;
  logic        InsideRectangle, shotActive;
  logic [10:0] offsetX, offsetY, topLeftX, topLeftY;

  int n_checks = 0;
  int n_pass   = 0;

  shot_rect_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .fire(fire),
    .launchX(launchX), .launchY(launchY), .collision(collision),
    .InsideRectangle(InsideRectangle), .offsetX(offsetX), .offsetY(offsetY),
    .shotActive(shotActive), .topLeftX(topLeftX), .topLeftY(topLeftY)
  );

  always #5 clk = ~clk;

  typedef struct {
    int px;
    int py;
    int ins;
    int ox;
    int oy;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    startOfFrame = 1'b0;
    fire         = 1'b0;
    collision    = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    #2 resetN = 1'b0;
    tick();
    #2 resetN = 1'b1;
    tick();
  endtask

  task automatic launch(input int x, input int y);
    launchX = 11'(x);
    launchY = 11'(y);
    fire    = 1'b1;
    tick();
    fire    = 1'b0;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  // reference model: a shot either exists at (mx,my), or is waiting out a number of frames
  int  mx, my, m_wait;
  bit  m_alive;
  int  e_in, e_ox, e_oy;

  task automatic model_step(input int px, input int py, input bit sof, input bit fi,
                            input bit col, input int lx, input int ly);
    e_in = (m_alive && px >= mx && px <= mx + 15 && py >= my && py <= my + 15) ? 1 : 0;
    e_ox = e_in ? px - mx : 0;
    e_oy = e_in ? py - my : 0;
    if (m_alive) begin
      if (col) begin
        m_alive = 0; m_wait = 8;
      end else if (sof) begin
        if (my < 4) begin
          m_alive = 0; m_wait = 8;
        end else begin
          my = my - 4;
        end
      end
    end else if (m_wait > 0) begin
      if (sof) m_wait--;
    end else if (fi) begin
      m_alive = 1;
      mx = (lx > 624) ? 624 : lx;
      my = ly;
    end
  endtask

  initial begin
    resetN = 1'b0;
    quiet();
    pixelX = '0; pixelY = '0; launchX = '0; launchY = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_active", int'(shotActive), 0);
    check("reset_inside", int'(InsideRectangle), 0);
    check("reset_x", int'(topLeftX), 0);
    check("reset_y", int'(topLeftY), 0);
    resetN = 1'b1;
    tick();

    // launch coincident with a frame pulse must not move; then three frames
    startOfFrame = 1'b1;
    launch(100, 200);
    startOfFrame = 1'b0;
    check("launch_active", int'(shotActive), 1);
    check("launch_x", int'(topLeftX), 100);
    check("launch_y", int'(topLeftY), 200);
    for (int i = 1; i <= 3; i++) begin
      frame();
      check("move_y", int'(topLeftY), 200 - 4 * i);
      check("move_x", int'(topLeftX), 100);
    end

    // fire while flying is ignored
    launch(300, 50);
    check("ignore_fire_x", int'(topLeftX), 100);
    check("ignore_fire_y", int'(topLeftY), 188);

    // rectangle table with topLeft=(100,188)
    vecs[0] = '{px: 100, py: 188, ins: 1, ox: 0,  oy: 0};
    vecs[1] = '{px: 115, py: 203, ins: 1, ox: 15, oy: 15};
    vecs[2] = '{px: 116, py: 188, ins: 0, ox: 0,  oy: 0};
    vecs[3] = '{px: 99,  py: 188, ins: 0, ox: 0,  oy: 0};
    vecs[4] = '{px: 107, py: 195, ins: 1, ox: 7,  oy: 7};
    vecs[5] = '{px: 100, py: 204, ins: 0, ox: 0,  oy: 0};
    vecs[6] = '{px: 115, py: 187, ins: 0, ox: 0,  oy: 0};
    vecs[7] = '{px: 103, py: 200, ins: 1, ox: 3,  oy: 12};
    for (int i = 0; i < 8; i++) begin
      pixelX = 11'(vecs[i].px);
      pixelY = 11'(vecs[i].py);
      tick();
      check("rect_inside", int'(InsideRectangle), vecs[i].ins);
      check("rect_offx", int'(offsetX), vecs[i].ox);
      check("rect_offy", int'(offsetY), vecs[i].oy);
    end

    // collision and frame pulse together: no move, cooldown holds position
    do_reset();
    launch(100, 50);
    collision = 1'b1; startOfFrame = 1'b1;
    tick();
    quiet();
    check("coll_active", int'(shotActive), 0);
    check("coll_y", int'(topLeftY), 50);
    frame();
    check("coll_hold_y", int'(topLeftY), 50);

    // top exit from y=3 then cooldown of 8 frames
    do_reset();
    launch(200, 7);
    frame();
    check("exit_pre_y", int'(topLeftY), 3);
    frame();
    check("exit_active", int'(shotActive), 0);
    check("exit_nowrap_y", int'(topLeftY), 3);
    launchY = 11'd40;
    for (int k = 1; k <= 8; k++) begin
      tick();
      fire = 1'b1; startOfFrame = 1'b1;
      tick();
      quiet();
      check("cooldown_ignore", int'(shotActive), 0);
    end
    tick();
    fire = 1'b1; startOfFrame = 1'b1;
    tick();
    quiet();
    check("ninth_frame_fire", int'(shotActive), 1);
    check("ninth_frame_y", int'(topLeftY), 40);

    // clip at the right edge
    do_reset();
    launch(630, 100);
    check("clip_x", int'(topLeftX), 624);

    // asynchronous reset mid-flight
    do_reset();
    pixelX = 11'd105; pixelY = 11'd105;
    launch(100, 100);
    tick();
    check("pre_reset_inside", int'(InsideRectangle), 1);
    check("pre_reset_offx", int'(offsetX), 5);
    #2 resetN = 1'b0;
    #1;
    check("async_active", int'(shotActive), 0);
    check("async_inside", int'(InsideRectangle), 0);
    check("async_offx", int'(offsetX), 0);
    check("async_offy", int'(offsetY), 0);
    check("async_x", int'(topLeftX), 0);
    check("async_y", int'(topLeftY), 0);
    #1 resetN = 1'b1;
    tick();
    check("post_reset_idle", int'(shotActive), 0);
    launch(10, 20);
    check("post_reset_launch", int'(shotActive), 1);

    // randomized run against the model
    do_reset();
    m_alive = 0; m_wait = 0; mx = 0; my = 0;
    for (int c = 0; c < 4000; c++) begin
      startOfFrame = ($urandom_range(0, 11) == 0);
      fire         = ($urandom_range(0, 7) == 0);
      collision    = ($urandom_range(0, 63) == 0);
      launchX      = 11'($urandom_range(0, 700));
      launchY      = 11'($urandom_range(0, 479));
      if ($urandom_range(0, 1) == 1) begin
        pixelX = 11'(mx + $urandom_range(0, 19) - 2);
        pixelY = 11'(my + $urandom_range(0, 19) - 2);
      end else begin
        pixelX = 11'($urandom_range(0, 2047));
        pixelY = 11'($urandom_range(0, 2047));
      end
      model_step(int'(pixelX), int'(pixelY), startOfFrame, fire, collision,
                 int'(launchX), int'(launchY));
      tick();
      check("rnd_inside", int'(InsideRectangle), e_in);
      check("rnd_offx", int'(offsetX), e_ox);
      check("rnd_offy", int'(offsetY), e_oy);
      check("rnd_active", int'(shotActive), int'(m_alive));
      check("rnd_x", int'(topLeftX), mx);
      check("rnd_y", int'(topLeftY), my);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
